// File: rtl/hazard_if.sv
// Hazard-control bundle: pipeline hazard sources in, register stall/flush controls out.
interface hazard_if #(
  parameter int REG_W = 4
);
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_reg_dst;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             mem_req;
  logic             dmem_ready;
  logic             wb_halt;

  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             stall_exmem;
  logic             stall_memwb;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             flush_memwb;

  // Pipeline side: reports hazard sources, obeys stall/flush.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_is_load, ex_reg_dst,
           ex_branch_taken, imem_ready, mem_req, dmem_ready, wb_halt,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb
  );

  // Scheduler side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_is_load, ex_reg_dst,
           ex_branch_taken, imem_ready, mem_req, dmem_ready, wb_halt,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline. Hazard responses are
// combinational; a small FSM tracks data-memory waits (with timeout) and HALT.
module hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_if.slave          hz,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DWAIT  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [REG_W-1:0]  rs1, rs2, dst;
  logic              dmem_stall, load_use;

  logic s_pc, s_ifid, s_idex, s_exmem, s_memwb;
  logic f_ifid, f_idex, f_exmem, f_memwb;

  assign rs1 = hz.id_rs1;
  assign rs2 = hz.id_rs2;
  assign dst = hz.ex_reg_dst;

  assign dmem_stall = hz.mem_req & ~hz.dmem_ready;
  assign load_use   = hz.ex_is_load &
                      ((hz.id_rs1_used & (rs1 == dst)) |
                       (hz.id_rs2_used & (rs2 == dst)));

  // Priority resolution of stall/flush controls for the current cycle.
  always_comb begin
    s_pc = 1'b0; s_ifid = 1'b0; s_idex = 1'b0; s_exmem = 1'b0; s_memwb = 1'b0;
    f_ifid = 1'b0; f_idex = 1'b0; f_exmem = 1'b0; f_memwb = 1'b0;
    if (state_reg == HALTED) begin
      s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1; s_memwb = 1'b1;
    end else if (dmem_stall) begin
      // Freeze everything up to MEM; WB receives a bubble. A taken branch in
      // EX is held in place and re-evaluated once the pipeline moves again.
      s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1;
      f_memwb = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // The ID instruction is wrong-path, so any load-use on it is irrelevant.
      f_ifid = 1'b1; f_idex = 1'b1;
    end else if (load_use) begin
      s_pc = 1'b1; s_ifid = 1'b1; f_idex = 1'b1;
    end else if (!hz.imem_ready) begin
      s_pc = 1'b1; f_ifid = 1'b1;
    end
  end

  assign hz.stall_pc    = s_pc;
  assign hz.stall_ifid  = s_ifid;
  assign hz.stall_idex  = s_idex;
  assign hz.stall_exmem = s_exmem;
  assign hz.stall_memwb = s_memwb;
  assign hz.flush_ifid  = f_ifid;
  assign hz.flush_idex  = f_idex;
  assign hz.flush_exmem = f_exmem;
  assign hz.flush_memwb = f_memwb;

  // Next-state logic: dmem wait tracking with timeout, HALT capture.
  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    mem_err_next = mem_err_reg;
    case (state_reg)
      RUN: begin
        if (hz.wb_halt) begin
          state_next = HALTED;
        end else if (dmem_stall) begin
          // The first stalled cycle already counts towards the timeout.
          state_next = DWAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      DWAIT: begin
        if (dmem_stall) begin
          if (wait_reg == WAIT_LAST) begin
            mem_err_next = 1'b1;
            state_next   = HALTED;
            wait_next    = '0;
          end else begin
            wait_next = wait_reg + WAIT_W'(1);
          end
        end else begin
          // Completed or request withdrawn.
          wait_next  = '0;
          state_next = hz.wb_halt ? HALTED : RUN;
        end
      end
      HALTED: state_next = HALTED;
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    count_next = count_reg;
    if (s_pc && (count_reg != {CNT_W{1'b1}}))
      count_next = count_reg + CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      wait_reg    <= '0;
      mem_err_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      mem_err_reg <= mem_err_next;
      count_reg   <= count_next;
    end
  end

  assign halted      = (state_reg == HALTED);
  assign mem_err     = mem_err_reg;
  assign stall_count = count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control vector order: stall pc,ifid,idex,exmem,memwb | flush ifid,idex,exmem,memwb
  localparam logic [8:0] C_NONE = 9'b00000_0000;
  localparam logic [8:0] C_LU   = 9'b11000_0100;
  localparam logic [8:0] C_BR   = 9'b00000_1100;
  localparam logic [8:0] C_IM   = 9'b10000_1000;
  localparam logic [8:0] C_DM   = 9'b11110_0001;
  localparam logic [8:0] C_HLT  = 9'b11111_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             halted, mem_err;
  logic [CNT_W-1:0] stall_count;
  logic [8:0]       ctrl;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  hazard_if #(.REG_W(4)) hz ();

  hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz),
    .halted(halted), .mem_err(mem_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign ctrl = {hz.stall_pc, hz.stall_ifid, hz.stall_idex, hz.stall_exmem, hz.stall_memwb,
                 hz.flush_ifid, hz.flush_idex, hz.flush_exmem, hz.flush_memwb};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle();
    hz.id_rs1 = 4'd0; hz.id_rs2 = 4'd0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
    hz.ex_is_load = 1'b0; hz.ex_reg_dst = 4'd0; hz.ex_branch_taken = 1'b0;
    hz.imem_ready = 1'b1; hz.mem_req = 1'b0; hz.dmem_ready = 1'b0; hz.wb_halt = 1'b0;
  endtask

  task automatic load_use_on();
    hz.ex_is_load = 1'b1; hz.ex_reg_dst = 4'd5; hz.id_rs2 = 4'd5; hz.id_rs2_used = 1'b1;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset ctrl", 32'(ctrl), 32'(C_NONE));
    check("reset halted", 32'(halted), 32'd0);
    check("reset mem_err", 32'(mem_err), 32'd0);
    check("reset count", 32'(stall_count), 32'd0);

    // Load-use on rs2.
    load_use_on(); #1;
    check("lu rs2 ctrl", 32'(ctrl), 32'(C_LU));
    tick(); exp_cnt++;
    idle(); #1;
    check("lu released", 32'(ctrl), 32'(C_NONE));
    check("lu count", 32'(stall_count), 32'(exp_cnt));

    // Register matches but operand not read: no hazard.
    hz.ex_is_load = 1'b1; hz.ex_reg_dst = 4'd7; hz.id_rs1 = 4'd7; #1;
    check("lu unused ctrl", 32'(ctrl), 32'(C_NONE));
    hz.id_rs1_used = 1'b1; #1;
    check("lu rs1 ctrl", 32'(ctrl), 32'(C_LU));
    tick(); exp_cnt++; idle(); #1;

    // Branch overrides load-use.
    load_use_on(); hz.ex_branch_taken = 1'b1; #1;
    check("br+lu ctrl", 32'(ctrl), 32'(C_BR));
    tick(); idle(); #1;
    check("br count", 32'(stall_count), 32'(exp_cnt));

    // Fetch wait alone, then fetch wait under load-use.
    hz.imem_ready = 1'b0; #1;
    check("imem ctrl", 32'(ctrl), 32'(C_IM));
    tick(); exp_cnt++;
    load_use_on(); #1;
    check("imem+lu ctrl", 32'(ctrl), 32'(C_LU));
    tick(); exp_cnt++; idle(); #1;
    check("imem count", 32'(stall_count), 32'(exp_cnt));

    // Data memory wait of 3 cycles, branch during the wait is masked.
    hz.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hz.ex_branch_taken = (i == 1); #1;
      check($sformatf("dwait%0d ctrl", i), 32'(ctrl), 32'(C_DM));
      tick(); exp_cnt++;
    end
    hz.ex_branch_taken = 1'b0; hz.dmem_ready = 1'b1; #1;
    check("dwait done ctrl", 32'(ctrl), 32'(C_NONE));
    tick(); idle(); #1;
    check("dwait count", 32'(stall_count), 32'(exp_cnt));
    check("dwait no err", 32'(mem_err), 32'd0);

    // Two stall cycles, then request withdrawn: wait counter must clear.
    hz.mem_req = 1'b1;
    tick(); tick(); exp_cnt += 2;
    hz.mem_req = 1'b0; #1;
    check("withdraw ctrl", 32'(ctrl), 32'(C_NONE));
    tick();

    // Timeout: error exactly after the 4th stalled cycle.
    hz.mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("tmo%0d ctrl", i), 32'(ctrl), 32'(C_DM));
      tick(); exp_cnt++;
      check($sformatf("tmo%0d mem_err", i), 32'(mem_err), 32'(i == 4));
      check($sformatf("tmo%0d halted", i), 32'(halted), 32'(i == 4));
    end
    check("tmo halted ctrl", 32'(ctrl), 32'(C_HLT));
    tick(); tick(); exp_cnt += 2;
    check("tmo count", 32'(stall_count), 32'(exp_cnt));

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0; #1;
    check("arst halted", 32'(halted), 32'd0);
    check("arst mem_err", 32'(mem_err), 32'd0);
    check("arst count", 32'(stall_count), 32'd0);
    idle(); #1;
    check("arst ctrl", 32'(ctrl), 32'(C_NONE));
    tick(); rst_n = 1'b1; exp_cnt = 0;

    // HALT from WB: one-cycle pulse latches permanently.
    hz.wb_halt = 1'b1; #1;
    check("halt req ctrl", 32'(ctrl), 32'(C_NONE));
    tick(); hz.wb_halt = 1'b0; #1;
    check("halt halted", 32'(halted), 32'd1);
    check("halt ctrl", 32'(ctrl), 32'(C_HLT));
    check("halt count0", 32'(stall_count), 32'd0);
    hz.ex_branch_taken = 1'b1; hz.imem_ready = 1'b0; #1;
    check("halt ignores inputs", 32'(ctrl), 32'(C_HLT));
    for (int i = 1; i <= 20; i++) begin
      tick(); exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      if (i == 1 || i == 2 || i == 15 || i == 20)
        check($sformatf("halt count%0d", i), 32'(stall_count), 32'(exp_cnt));
    end
    check("halt persists", 32'(halted), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the stall and flush inputs of the PC, IF_ID_reg, ID_EX_reg, EX_MEM_reg and MEM_WB_reg.
- Resolves load-use hazards, taken branches, instruction-memory and data-memory wait states, and HALT.
- Holds a data-memory timeout FSM and a saturating stall-cycle counter.

Parameters:
- REG_W, 4, register-index width (16 GPRs)
- MEM_TIMEOUT, 64, max consecutive dmem wait cycles before error (>=2)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_rs1  in  REG_W  ID-stage source reg 1
- id_rs2  in  REG_W  ID-stage source reg 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_is_load  in  1  EX-stage instruction is a load (or pop/return read)
- ex_reg_dst  in  REG_W  EX-stage destination reg
- ex_branch_taken  in  1  pc_branch_sel from Branch_Logic (EX)
- imem_ready  in  1  instruction fetch data valid this cycle
- mem_req  in  1  MEM stage performs load/store
- dmem_ready  in  1  data memory completes this cycle
- wb_halt  in  1  HALT instruction in WB
- stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb  out  1 each  hold register
- flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1 each  load bubble at next edge
- halted  out  1  core halted
- mem_err  out  1  dmem timeout, sticky
- stall_count  out  CNT_W  cycles with stall_pc=1, saturating

Behaviour:
- State: RUN, DWAIT, HALTED.
- Reset (async): state=RUN, wait counter=0, halted=0, mem_err=0, stall_count=0.
- Stall/flush outputs are combinational from state and inputs. With all inputs at 0 in RUN, all outputs are 0.
- HALTED:
  - All stall_*=1 and all flush_*=0.
  - halted=1.
  - Left only by reset.
- Outside HALTED, evaluate in priority order:
  1. dmem_stall = mem_req & ~dmem_ready:
     - stall_pc, stall_ifid, stall_idex, stall_exmem = 1.
     - flush_memwb=1 (bubble into WB).
     - All other hazards are masked this cycle, including branch flush; the branch is re-presented when EX advances.
  2. ex_branch_taken: flush_ifid=1, flush_idex=1, no stalls. Branch overrides load-use, because the ID instruction is wrong-path.
  3. load_use = ex_is_load & ((id_rs1_used & id_rs1==ex_reg_dst) | (id_rs2_used & id_rs2==ex_reg_dst)):
     - stall_pc=1, stall_ifid=1, flush_idex=1.
     - Later stages advance.
  4. ~imem_ready: stall_pc=1, flush_ifid=1. Applies only if neither 2 nor 3 is active. If 3 is active, the 3 outputs stand and stall_pc stays 1.
- FSM transitions:
  - RUN -> DWAIT when dmem_stall.
  - DWAIT:
    - Wait counter increments each cycle dmem_stall=1.
    - dmem_ready=1: stalls release that cycle, counter clears, -> RUN.
    - Counter reaches MEM_TIMEOUT-1 with dmem_stall still 1: mem_err<=1, -> HALTED.
    - mem_req dropping (e.g., flush) also returns to RUN with counter cleared.
  - Any state -> HALTED when wb_halt=1 at a clock edge, except DWAIT with dmem_stall (WB gets a bubble, so wb_halt cannot be legitimately asserted there). halted is asserted from the following cycle.
- stall_count:
  - +1 per cycle with stall_pc=1, including HALTED.
  - Holds at 2^CNT_W-1.
- Latency:
  - Hazard response is 0-cycle (same cycle as the cause).
  - halted and mem_err appear 1 cycle after the triggering edge.
- Reset mid-DWAIT or in HALTED returns to RUN immediately (asynchronous).

Test Plan:
- ex_is_load=1, ex_reg_dst=5, id_rs2=5, id_rs2_used=1, one cycle -> stall_pc=stall_ifid=flush_idex=1 for exactly that cycle; stall_count=1.
- Same load-use plus ex_branch_taken=1 -> flush_ifid=flush_idex=1, stall_pc=0; stall_count unchanged.
- mem_req=1, dmem_ready=0 for 3 cycles then 1 -> stall_pc..stall_exmem=1 and flush_memwb=1 for 3 cycles, released on the 4th; state back to RUN; branch asserted during the wait produces no flush.
- MEM_TIMEOUT=4, mem_req=1, dmem_ready=0 held -> mem_err=1 and halted=1 after the 4th wait cycle; all stalls stay 1; rst_n pulse clears everything.
- wb_halt=1 for one cycle -> halted=1 next cycle and permanently; all stall_*=1; stall_count increments each cycle.
- CNT_W=4, stall_pc held 20 cycles -> stall_count saturates at 15.
